// File: rtl/qos_wrr_arbiter.sv
// Two-channel weighted-round-robin scheduler with an almost-full urgency override.
// Pops are combinational; the granted word, its valid flag and its VC select are registered.
module qos_wrr_arbiter #(
  parameter int DATA_WIDTH = 6,
  parameter int WEIGHT_W   = 4,
  parameter int WEIGHT0    = 3,
  parameter int WEIGHT1    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enb,
  input  logic                  vc0_empty,
  input  logic                  vc1_empty,
  input  logic                  vc0_almost_full,
  input  logic                  vc1_almost_full,
  input  logic [DATA_WIDTH-1:0] vc0_data,
  input  logic [DATA_WIDTH-1:0] vc1_data,
  input  logic                  out_ready,
  output logic                  pop_vc0,
  output logic                  pop_vc1,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  selector
);

  // A weight of zero still grants one word per turn.
  localparam logic [WEIGHT_W-1:0] W0 = (WEIGHT0 == 0) ? WEIGHT_W'(1) : WEIGHT_W'(WEIGHT0);
  localparam logic [WEIGHT_W-1:0] W1 = (WEIGHT1 == 0) ? WEIGHT_W'(1) : WEIGHT_W'(WEIGHT1);

  typedef enum logic [1:0] {IDLE, SERVE0, SERVE1} state_t;

  state_t                state_q, state_d;
  logic [WEIGHT_W-1:0]   cnt_q, cnt_d;
  logic                  last_q, last_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  vld_q;
  logic                  sel_q;

  logic                  can, elig0, elig1, urg0, urg1;
  logic                  gnt, gsel, urgent;
  logic [WEIGHT_W-1:0]   gcnt, wk;
  logic [WEIGHT_W:0]     cnt_inc;

  // Reset in the gate keeps pops low for the whole reset cycle.
  assign can   = enb & out_ready & ~reset;
  assign elig0 = can & ~vc0_empty;
  assign elig1 = can & ~vc1_empty;
  assign urg1  = elig1 & vc1_almost_full & ~vc0_almost_full;
  assign urg0  = elig0 & vc0_almost_full & ~vc1_almost_full;

  always_comb begin
    gnt     = 1'b0;
    gsel    = 1'b0;
    gcnt    = cnt_q;
    urgent  = 1'b0;
    wk      = W0;
    cnt_inc = '0;
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;

    if (urg1) begin
      gnt    = 1'b1;
      gsel   = 1'b1;
      urgent = 1'b1;
    end else if (urg0) begin
      gnt    = 1'b1;
      gsel   = 1'b0;
      urgent = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (elig0 && elig1) begin
            gnt  = 1'b1;
            gsel = ~last_q;
            gcnt = '0;
          end else if (elig0 || elig1) begin
            gnt  = 1'b1;
            gsel = elig1;
            gcnt = '0;
          end
        end
        SERVE0: begin
          if (elig0) begin
            gnt  = 1'b1;
            gsel = 1'b0;
          end else if (elig1) begin
            gnt  = 1'b1;
            gsel = 1'b1;
            gcnt = '0;
          end else if (can) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        SERVE1: begin
          if (elig1) begin
            gnt  = 1'b1;
            gsel = 1'b1;
          end else if (elig0) begin
            gnt  = 1'b1;
            gsel = 1'b0;
            gcnt = '0;
          end else if (can) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Extra bit on the increment keeps a weight of 2^WEIGHT_W-1 from wrapping.
    wk      = gsel ? W1 : W0;
    cnt_inc = {1'b0, gcnt} + 1'b1;
    if (gnt) begin
      last_d = gsel;
      if (!urgent) begin
        if (cnt_inc >= {1'b0, wk}) begin
          state_d = gsel ? SERVE0 : SERVE1;
          cnt_d   = '0;
        end else begin
          state_d = gsel ? SERVE1 : SERVE0;
          cnt_d   = cnt_inc[WEIGHT_W-1:0];
        end
      end
    end
  end

  assign pop_vc0 = gnt & ~gsel;
  assign pop_vc1 = gnt & gsel;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      data_q  <= '0;
      vld_q   <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      vld_q   <= gnt;
      if (gnt) begin
        data_q <= gsel ? vc1_data : vc0_data;
        sel_q  <= gsel;
      end
    end
  end

  assign data_out  = data_q;
  assign valid_out = vld_q;
  assign selector  = sel_q;

endmodule

// File: tb/tb_qos_wrr_arbiter.sv
// Directed bench: per-cycle pop checks plus a scoreboard of expected registered outputs.
module tb_qos_wrr_arbiter;

  logic       clk = 1'b0;
  logic       reset, enb, vc0_empty, vc1_empty, vc0_af, vc1_af, out_ready;
  logic [5:0] vc0_data, vc1_data, data_out;
  logic       pop_vc0, pop_vc1, valid_out, selector;

  typedef struct {
    logic       v;
    logic [5:0] d;
    logic       s;
    string      nm;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc_n = 0;
  logic [5:0] hold_d = '0;
  logic       hold_s = 1'b0;

  qos_wrr_arbiter #(.DATA_WIDTH(6), .WEIGHT_W(4), .WEIGHT0(3), .WEIGHT1(1)) dut (
    .clk(clk), .reset(reset), .enb(enb),
    .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
    .vc0_almost_full(vc0_af), .vc1_almost_full(vc1_af),
    .vc0_data(vc0_data), .vc1_data(vc1_data), .out_ready(out_ready),
    .pop_vc0(pop_vc0), .pop_vc1(pop_vc1),
    .data_out(data_out), .valid_out(valid_out), .selector(selector)
  );

  always #5 clk = ~clk;

  // exp: 0 = no pop, 1 = pop VC0, 2 = pop VC1
  task automatic step(input logic rst, input logic en, input logic rdy,
                      input logic ne0, input logic ne1, input logic af0, input logic af1,
                      input int exp, input string nm);
    exp_t e;
    logic [1:0] pe;
    logic [5:0] c5;
    c5 = 6'(cyc_n % 32);
    reset = rst; enb = en; out_ready = rdy;
    vc0_empty = ~ne0; vc1_empty = ~ne1; vc0_af = af0; vc1_af = af1;
    vc0_data = c5;
    vc1_data = 6'h20 | c5;
    #1;
    pe = (exp == 1) ? 2'b10 : (exp == 2) ? 2'b01 : 2'b00;
    n_vec++;
    if ({pop_vc0, pop_vc1} != pe) begin
      n_bad++;
      $display("FAIL pop %s cyc%0d: got pop0/pop1=%b required %b", nm, cyc_n, {pop_vc0, pop_vc1}, pe);
    end
    if (rst) begin
      hold_d = '0; hold_s = 1'b0;
    end else if (exp == 1) begin
      hold_d = c5; hold_s = 1'b0;
    end else if (exp == 2) begin
      hold_d = 6'h20 | c5; hold_s = 1'b1;
    end
    e.v = (exp != 0) && !rst;
    e.d = hold_d;
    e.s = hold_s;
    e.nm = nm;
    sb_q.push_back(e);
    cyc_n++;
    @(negedge clk);
  endtask

  // Monitor: every negedge consumes the record for the preceding clock edge.
  always @(negedge clk) begin
    exp_t r;
    if (sb_q.size() > 0) begin
      r = sb_q.pop_front();
      n_vec++;
      if (valid_out !== r.v || data_out !== r.d || selector !== r.s) begin
        n_bad++;
        $display("FAIL out %s: got v=%b d=%h s=%b required v=%b d=%h s=%b",
                 r.nm, valid_out, data_out, selector, r.v, r.d, r.s);
      end
    end
  end

  initial begin
    reset = 1'b1; enb = 1'b0; out_ready = 1'b0; vc0_empty = 1'b1; vc1_empty = 1'b1;
    vc0_af = 1'b0; vc1_af = 1'b0; vc0_data = '0; vc1_data = '0;
    @(negedge clk);

    // A: steady 3:1 pattern
    step(1,1,1,1,1,0,0, 0, "A_rst");
    for (int i = 0; i < 8; i++)
      step(0,1,1,1,1,0,0, (i % 4 == 3) ? 2 : 1, "A_wrr");

    // B: VC1 alone, then VC0 joins with no bubble
    step(1,1,1,0,0,0,0, 0, "B_rst");
    for (int i = 0; i < 5; i++) step(0,1,1,0,1,0,0, 2, "B_vc1only");
    step(0,1,1,1,1,0,0, 1, "B_join");
    step(0,1,1,1,1,0,0, 1, "B_join");
    step(0,1,1,1,1,0,0, 1, "B_join");
    step(0,1,1,1,1,0,0, 2, "B_join");

    // C: urgency override mid-turn, both-almost-full, VC0 urgency in SERVE1
    step(1,1,1,0,0,0,0, 0, "C_rst");
    step(0,1,1,1,1,0,0, 1, "C_g0");
    step(0,1,1,1,1,0,1, 2, "C_urg1");
    step(0,1,1,1,1,0,0, 1, "C_resume");
    step(0,1,1,1,1,0,0, 1, "C_resume");
    step(0,1,1,1,1,0,0, 2, "C_turn1");
    for (int i = 0; i < 3; i++) step(0,1,1,1,1,0,0, 1, "C_g0b");
    step(0,1,1,1,1,1,1, 2, "C_bothaf");
    for (int i = 0; i < 3; i++) step(0,1,1,1,1,0,0, 1, "C_g0c");
    step(0,1,1,1,1,1,0, 1, "C_urg0");
    step(0,1,1,1,1,0,0, 2, "C_after_urg0");

    // D: out_ready toggling, then enb gap mid-turn
    step(1,1,1,0,0,0,0, 0, "D_rst");
    for (int i = 0; i < 10; i++)
      step(0,1,(i % 2 == 0),1,1,0,0, (i % 2 == 1) ? 0 : (i == 6) ? 2 : 1, "D_rdy");
    step(0,1,1,1,1,0,0, 1, "D_pre_enb");
    step(0,0,1,1,1,0,0, 0, "D_enb_lo");
    step(0,0,1,1,1,0,0, 0, "D_enb_lo");
    step(0,1,1,1,1,0,0, 1, "D_resume");
    step(0,1,1,1,1,0,0, 2, "D_resume");

    // E: drain to IDLE, refill goes to channel not last served
    step(1,1,1,0,0,0,0, 0, "E_rst");
    step(0,1,1,1,1,0,0, 1, "E_g0");
    step(0,1,1,1,1,0,0, 1, "E_g0");
    step(0,1,1,0,0,0,0, 0, "E_drain");
    step(0,1,1,0,0,0,0, 0, "E_idle");
    step(0,1,1,1,1,0,0, 2, "E_refill");
    step(0,1,1,1,1,0,0, 1, "E_after");

    // F: reset in the middle of traffic
    step(1,1,1,0,0,0,0, 0, "F_rst");
    step(0,1,1,1,1,0,0, 1, "F_g");
    step(0,1,1,1,1,0,0, 1, "F_g");
    step(0,1,1,1,1,0,0, 1, "F_g");
    step(0,1,1,1,1,0,0, 2, "F_g");
    step(1,1,1,1,1,0,0, 0, "F_rst_traffic");
    step(0,1,1,1,1,0,0, 1, "F_post_rst");
    step(0,1,1,1,1,0,0, 1, "F_post_rst");

    #2;
    n_vec++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: got %0d pending records required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/qos_wrr_arbiter.md
Name: qos_wrr_arbiter

Overview:
- Two-channel weighted-round-robin scheduler for the QoS translation datapath.
- Shares one downstream output lane between two virtual-channel FIFOs (VC0, VC1). It decides which FIFO is popped each cycle and drives the lane select.
- Registers the selected word onto the output lane, together with a valid flag and the VC select.
- Includes an almost-full urgency override so a backed-up channel is drained ahead of the weighted schedule.

Parameters:
- DATA_WIDTH, 6, width of each VC data word and of data_out.
- WEIGHT_W, 4, width of the weight constants and of the grant counter.
- WEIGHT0, 3, consecutive normal grants allowed to VC0 per turn; 0 is treated as 1.
- WEIGHT1, 1, consecutive normal grants allowed to VC1 per turn; 0 is treated as 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enb  input  1  block enable; when low, no grants are issued.
- vc0_empty  input  1  VC0 FIFO empty.
- vc1_empty  input  1  VC1 FIFO empty.
- vc0_almost_full  input  1  VC0 FIFO almost-full flag.
- vc1_almost_full  input  1  VC1 FIFO almost-full flag.
- vc0_data  input  DATA_WIDTH  VC0 show-ahead head word, valid while !vc0_empty.
- vc1_data  input  DATA_WIDTH  VC1 show-ahead head word, valid while !vc1_empty.
- out_ready  input  1  downstream can accept a word this cycle.
- pop_vc0  output  1  combinational read strobe to VC0.
- pop_vc1  output  1  combinational read strobe to VC1.
- data_out  output  DATA_WIDTH  registered granted word.
- valid_out  output  1  registered; data_out is valid.
- selector  output  1  registered; 0 = VC0, 1 = VC1 sourced data_out.

Behaviour:
- Clock and reset: one clock domain (clk); reset is synchronous and active-high.
- Reset values: state=IDLE, cnt=0, last=1 (so VC0 is served first after reset), pop_vc0=0, pop_vc1=0, data_out=0, valid_out=0, selector=0.
- Grant gating: can = enb & out_ready. When can=0, there are no pops, state, cnt and last hold, and valid_out=0 on the next edge.
- Eligibility: eligible0 = can & !vc0_empty; eligible1 = can & !vc1_empty.
- Effective weights: W0 = max(WEIGHT0,1); W1 = max(WEIGHT1,1).
- Urgency (evaluated first):
  - If eligible1 & vc1_almost_full & !vc0_almost_full, grant VC1.
  - Symmetrically, if eligible0 & vc0_almost_full & !vc1_almost_full, grant VC0.
  - Urgent grants leave state and cnt unchanged; they do update last.
  - If both channels are almost-full, the normal schedule applies.
- FSM states: IDLE, SERVE0, SERVE1. "Grant k with cnt" means pop k; next cnt = cnt+1; if cnt+1 >= Wk, the next state is SERVE(other) with cnt=0, otherwise SERVEk.
- IDLE:
  - Both channels eligible: grant the channel != last, starting from cnt=0.
  - Only one eligible: grant it from cnt=0.
  - Neither eligible: stay in IDLE.
- SERVEk:
  - eligible_k: grant k.
  - Else if eligible_other: switch to SERVE(other) and grant it with cnt=0 in the same cycle (work-conserving, no bubble).
  - Else if can=1 and both FIFOs are empty: go to IDLE with cnt=0.
- One-hot grant: at most one pop per cycle; pop_vc0 & pop_vc1 is never 1.
- A pop is never asserted on an empty FIFO.
- Output latency:
  - The pop in cycle N produces, at edge N+1: data_out = the popped vck_data, selector = k, valid_out = 1, last = k.
  - When there is no pop, valid_out = 0 and data_out/selector hold.
- enb deasserted mid-turn: cnt and state are frozen, and the turn resumes where it left off when enb returns.
- reset during traffic: reset overrides everything on that edge, including a pop in the same cycle. pop outputs are combinational and gated by !reset, so they are 0 while reset is high.
- cnt never exceeds max(W0,W1). Widths: cnt is WEIGHT_W bits; a weight of 2^WEIGHT_W-1 is legal.

Test Plan:
- Reset, then both FIFOs continuously non-empty, out_ready=1, enb=1, W0=3, W1=1 -> pop pattern 0,0,0,1,0,0,0,1; selector one cycle later matches; valid_out=1 continuously.
- Only VC1 non-empty for 5 cycles, then VC0 also becomes non-empty -> 5 consecutive VC1 grants. The VC1 turn is forced after each VC1 grant because W1=1, so the next grant is VC0 as soon as it is non-empty, with no idle cycle.
- Both non-empty, vc1_almost_full=1 during the second VC0 grant of a turn -> VC1 is granted that cycle. cnt stays 1, and after the override VC0 finishes its turn with 2 more grants.
- out_ready toggling 1,0,1,0 with both non-empty -> pops only in ready cycles, and the 3:1 pattern is preserved across the gaps. valid_out=0 in the cycle after each non-ready cycle.
- Both FIFOs drain to empty mid-turn -> FSM goes to IDLE with pops=0. On refill of both FIFOs, the first grant goes to the channel not last served.
- reset asserted during active traffic for 1 cycle -> pops=0 that cycle; next edge gives valid_out=0, data_out=0, selector=0; the following grant goes to VC0.
